// File: rtl/stack_sequencer.sv
// Sequences Forth-style stack ops into spaced push/drop pulses for the data stack,
// tracking depth so underflow/overflow are rejected before any pulse is issued.
module stack_sequencer #(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 64,
  localparam int DW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             err_clr,
  output logic [DW-1:0]    depth,
  output logic             stk_push,
  output logic             stk_drop,
  output logic [WIDTH-1:0] stk_D,
  input  logic [WIDTH-1:0] stk_top,
  input  logic [WIDTH-1:0] stk_next
);

  typedef enum logic [1:0] {IDLE, ACT, GAP} state_t;

  // action encoding: a drop, or a push whose data comes from literal / T / N
  localparam logic [1:0] A_DROP = 2'd0;
  localparam logic [1:0] A_LIT  = 2'd1;
  localparam logic [1:0] A_T    = 2'd2;
  localparam logic [1:0] A_N    = 2'd3;

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d, cnt_q, cnt_d;
  logic [3:0][1:0]      acts_q, acts_d;
  logic [WIDTH-1:0]     lit_q, lit_d, t_q, t_d, n_q, n_d, stkd_q, stkd_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;

  logic [2:0]           dec_cnt;
  logic [3:0][1:0]      dec_acts;
  logic [DW-1:0]        need;
  logic                 grow, under, over, acc;

  function automatic logic [WIDTH-1:0] pick(input logic [1:0] a, input logic [WIDTH-1:0] l,
                                            input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] n);
    case (a)
      A_T:     pick = t;
      A_N:     pick = n;
      default: pick = l;
    endcase
  endfunction

  always_comb begin
    dec_cnt  = 3'd0;
    dec_acts = '0;
    need     = '0;
    grow     = 1'b0;
    case (op)
      3'd1: begin dec_cnt = 3'd1; dec_acts[0] = A_LIT; grow = 1'b1; end
      3'd2: begin dec_cnt = 3'd1; need = DW'(1); end
      3'd3: begin dec_cnt = 3'd1; dec_acts[0] = A_T; need = DW'(1); grow = 1'b1; end
      3'd4: begin dec_cnt = 3'd4; dec_acts = {A_N, A_T, A_DROP, A_DROP}; need = DW'(2); end
      3'd5: begin dec_cnt = 3'd1; dec_acts[0] = A_N; need = DW'(2); grow = 1'b1; end
      3'd6: begin dec_cnt = 3'd3; dec_acts = {A_DROP, A_T, A_DROP, A_DROP}; need = DW'(2); end
      default: ;
    endcase
  end

  assign acc   = op_valid && (state_q == IDLE);
  assign under = depth_q < need;
  assign over  = !under && grow && (depth_q == DW'(DEPTH));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    acts_d  = acts_q;
    lit_d   = lit_q;
    t_d     = t_q;
    n_d     = n_q;
    stkd_d  = stkd_q;
    depth_d = depth_q;
    err_d   = err_q;
    code_d  = code_q;
    case (state_q)
      IDLE: if (acc) begin
        lit_d  = op_data;
        t_d    = stk_top;
        n_d    = stk_next;
        acts_d = dec_acts;
        idx_d  = 3'd0;
        if (under || over || dec_cnt == 3'd0) begin
          cnt_d   = 3'd0;
          state_d = GAP;
        end else begin
          cnt_d   = dec_cnt;
          state_d = ACT;
          if (dec_acts[0] != A_DROP) stkd_d = pick(dec_acts[0], op_data, stk_top, stk_next);
        end
      end
      ACT: begin
        depth_d = (acts_q[idx_q[1:0]] == A_DROP) ? depth_q - DW'(1) : depth_q + DW'(1);
        idx_d   = idx_q + 3'd1;
        state_d = GAP;
      end
      GAP: begin
        if (idx_q == cnt_q) begin
          state_d = IDLE;
        end else begin
          state_d = ACT;
          if (acts_q[idx_q[1:0]] != A_DROP) stkd_d = pick(acts_q[idx_q[1:0]], lit_q, t_q, n_q);
        end
      end
      default: state_d = IDLE;
    endcase
    // a fresh error beats a simultaneous clear; the code only latches the first error
    if (acc && (under || over)) begin
      err_d = 1'b1;
      if (!err_q || err_clr) code_d = under ? 2'b01 : 2'b10;
    end else if (err_clr) begin
      err_d  = 1'b0;
      code_d = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      acts_q  <= '0;
      lit_q   <= '0;
      t_q     <= '0;
      n_q     <= '0;
      stkd_q  <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acts_q  <= acts_d;
      lit_q   <= lit_d;
      t_q     <= t_d;
      n_q     <= n_d;
      stkd_q  <= stkd_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // pulses decode straight from state so an async reset drops them at once
  assign op_ready = (state_q == IDLE);
  assign done     = (state_q == GAP) && (idx_q == cnt_q);
  assign stk_push = (state_q == ACT) && (acts_q[idx_q[1:0]] != A_DROP);
  assign stk_drop = (state_q == ACT) && (acts_q[idx_q[1:0]] == A_DROP);
  assign stk_D    = stkd_q;
  assign depth    = depth_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: issue() predicts pulses/done per op from a
// reference stack; a negedge monitor pops and compares each DUT event.
module tb_stack_sequencer;
  localparam int W = 36;
  localparam int D = 64;

  logic         clk = 0, rst_n = 0;
  logic         op_valid = 0, err_clr = 0;
  logic [2:0]   op = 0;
  logic [W-1:0] op_data = 0;
  logic         op_ready, done, err, stk_push, stk_drop;
  logic [1:0]   err_code;
  logic [6:0]   depth;
  logic [W-1:0] stk_D, top_r = 0, next_r = 0;

  stack_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .op_data(op_data),
    .op_ready(op_ready), .done(done), .err(err), .err_code(err_code), .err_clr(err_clr),
    .depth(depth), .stk_push(stk_push), .stk_drop(stk_drop), .stk_D(stk_D),
    .stk_top(top_r), .stk_next(next_r));

  always #5 clk = ~clk;

  typedef struct {int kind; logic [W-1:0] data; int cyc; bit err; logic [1:0] code; int depth;} ev_t;
  ev_t          exp_q[$];
  logic [W-1:0] refs[$];
  logic [W-1:0] env[$];
  bit           m_err = 0;
  logic [1:0]   m_code = 0;
  int           cyc = 0, checks = 0, errors = 0;
  bit           prev_pulse = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural stack fed by the DUT's pulses, supplying stk_top/stk_next
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) env.delete();
    else if (stk_push) env.push_back(stk_D);
    else if (stk_drop && env.size() > 0) void'(env.pop_back());
    top_r  <= (env.size() > 0) ? env[env.size()-1] : '0;
    next_r <= (env.size() > 1) ? env[env.size()-2] : '0;
  end

  always @(negedge clk) begin
    ev_t e;
    int  k;
    bit  ok;
    if (rst_n) begin
      if ((stk_push || stk_drop) && (prev_pulse || (stk_push && stk_drop))) begin
        checks++; errors++;
        $display("FAIL pulse_spacing: push=%b drop=%b prev=%b at cyc %0d", stk_push, stk_drop, prev_pulse, cyc);
      end
      if (stk_push || stk_drop || done) begin
        k = done ? 2 : (stk_push ? 1 : 0);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: kind=%0d cyc=%0d, none expected", k, cyc);
        end else begin
          e  = exp_q.pop_front();
          ok = (k == e.kind) && (cyc == e.cyc) && (k != 1 || stk_D == e.data) &&
               (k != 2 || (err == e.err && err_code == e.code && int'(depth) == e.depth));
          if (!ok) begin
            errors++;
            $display("FAIL event: got kind=%0d cyc=%0d D=%h err=%b code=%b depth=%0d, want kind=%0d cyc=%0d D=%h err=%b code=%b depth=%0d",
                     k, cyc, stk_D, err, err_code, depth, e.kind, e.cyc, e.data, e.err, e.code, e.depth);
          end
        end
      end
    end
    prev_pulse = rst_n && (stk_push || stk_drop);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] dat, input bit clr, input int hold);
    int w = 0, n, k, a, need;
    bit grow, rej, und;
    int kinds[4];
    logic [W-1:0] t, nn, dv;
    ev_t e;
    @(negedge clk);
    while (!op_ready && w < 100) begin @(negedge clk); w++; end
    if (!op_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: op_ready=%b after %0d cycles, want 1", op_ready, w);
      return;
    end
    n = refs.size();
    t  = (n > 0) ? refs[n-1] : '0;
    nn = (n > 1) ? refs[n-2] : '0;
    // kinds: 0 drop, 1 push literal, 2 push T, 3 push N
    k = 0; need = 0; grow = 0;
    case (o)
      3'd1: begin k = 1; kinds[0] = 1; grow = 1; end
      3'd2: begin k = 1; kinds[0] = 0; need = 1; end
      3'd3: begin k = 1; kinds[0] = 2; need = 1; grow = 1; end
      3'd4: begin k = 4; kinds = '{0, 0, 2, 3}; need = 2; end
      3'd5: begin k = 1; kinds[0] = 3; need = 2; grow = 1; end
      3'd6: begin k = 3; kinds = '{0, 0, 2, 0}; need = 2; end
      default: k = 0;
    endcase
    und = n < need;
    rej = und || (grow && n == D);
    if (rej) begin
      if (!m_err || clr) m_code = und ? 2'b01 : 2'b10;
      m_err = 1;
      k = 0;
    end else if (clr) begin
      m_err = 0; m_code = 2'b00;
    end
    op_valid = 1; op = o; op_data = dat; err_clr = clr;
    @(posedge clk); #1;
    a = cyc;
    for (int j = 0; j < k; j++) begin
      dv = (kinds[j] == 1) ? dat : (kinds[j] == 2) ? t : nn;
      e = '{kind: (kinds[j] == 0) ? 0 : 1, data: dv, cyc: a + 2*j, err: 0, code: 0, depth: 0};
      exp_q.push_back(e);
      if (kinds[j] == 0) void'(refs.pop_back());
      else refs.push_back(dv);
    end
    e = '{kind: 2, data: '0, cyc: (k == 0) ? a : a + 2*k - 1, err: m_err, code: m_code, depth: refs.size()};
    exp_q.push_back(e);
    @(negedge clk);
    err_clr = 0;
    repeat (hold) @(negedge clk);
    op_valid = 0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || !op_ready) && w < 200) begin @(negedge clk); w++; end
    if (exp_q.size() != 0 || !op_ready) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d events pending, op_ready=%b", exp_q.size(), op_ready);
      exp_q.delete();
    end
  endtask

  task automatic clear_err();
    drain();
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    m_err = 0; m_code = 2'b00;
    chk("err_after_clr", {63'd0, err}, 64'd0);
    chk("code_after_clr", {62'd0, err_code}, 64'd0);
  endtask

  initial begin
    #12;
    chk("rst_op_ready", {63'd0, op_ready}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_code", {62'd0, err_code}, 64'd0);
    chk("rst_depth", {57'd0, depth}, 64'd0);
    chk("rst_push", {63'd0, stk_push}, 64'd0);
    chk("rst_drop", {63'd0, stk_drop}, 64'd0);
    chk("rst_stkD", {28'd0, stk_D}, 64'd0);
    @(negedge clk); rst_n = 1;

    issue(3'd1, 36'h1, 0, 0);
    issue(3'd1, 36'h2, 0, 0);
    issue(3'd1, 36'h3, 0, 0);
    issue(3'd4, 36'h0, 0, 0);            // SWAP: stack 1,3,2
    issue(3'd2, 36'h0, 0, 0);
    issue(3'd2, 36'h0, 0, 0);            // depth 1
    issue(3'd5, 36'h0, 0, 0);            // OVER underflow
    drain();
    chk("over_uflow_err", {63'd0, err}, 64'd1);
    chk("over_uflow_code", {62'd0, err_code}, 64'd1);
    clear_err();
    issue(3'd3, 36'h0, 0, 0);            // DUP
    issue(3'd6, 36'h0, 0, 0);            // NIP
    issue(3'd0, 36'h5, 0, 0);            // NOP
    issue(3'd7, 36'h5, 0, 0);            // reserved
    issue(3'd5, 36'h0, 0, 0);            // underflow, code 01
    for (int i = 0; i < D - 1; i++) issue(3'd1, 36'h100 + 36'(i), 0, 0);
    issue(3'd3, 36'h0, 0, 0);            // overflow, code stays 01
    drain();
    chk("full_depth", {57'd0, depth}, 64'd64);
    clear_err();
    issue(3'd3, 36'h0, 0, 0);            // overflow, code 10
    issue(3'd2, 36'h0, 0, 0);            // depth 63, err sticky
    drain();
    chk("sticky_err", {63'd0, err}, 64'd1);
    chk("sticky_code", {62'd0, err_code}, 64'd2);

    @(negedge clk); rst_n = 0;
    refs.delete(); m_err = 0; m_code = 0;
    @(negedge clk); rst_n = 1;
    issue(3'd2, 36'h0, 0, 0);            // underflow at depth 0
    issue(3'd2, 36'h0, 1, 0);            // clear + new underflow together
    drain();
    chk("clr_vs_new_err", {63'd0, err}, 64'd1);

    issue(3'd1, 36'hA, 0, 0);
    issue(3'd1, 36'hB, 0, 0);
    issue(3'd4, 36'h0, 0, 0);            // returns at negedge of cycle 1
    @(negedge clk); @(negedge clk);      // cycle 3: second drop in progress
    #2 rst_n = 0;
    #1;
    chk("abort_drop", {63'd0, stk_drop}, 64'd0);
    chk("abort_push", {63'd0, stk_push}, 64'd0);
    chk("abort_depth", {57'd0, depth}, 64'd0);
    exp_q.delete(); refs.delete(); m_err = 0; m_code = 0;
    @(negedge clk); rst_n = 1;
    #1 chk("abort_ready", {63'd0, op_ready}, 64'd1);

    issue(3'd1, 36'hC, 0, 1);            // op_valid held through the busy cycles
    issue(3'd1, 36'hD, 0, 0);
    issue(3'd5, 36'h0, 0, 0);            // OVER pushes C
    drain();
    chk("final_depth", {57'd0, depth}, 64'(refs.size()));
    chk("final_err", {63'd0, err}, {63'd0, m_err});
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
